// File: rtl/regfile_mp_if.sv
// Bundles the read, writeback and reserve buses of regfile_mp.
// The master side is issue/writeback; the slave side is the register file itself.
interface regfile_mp_if #(
    parameter int XLEN         = 32,
    parameter int NUM_REGS     = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int NUM_WR_PORTS = 1,
    parameter int ADDR_W       = $clog2(NUM_REGS)
);
    logic [NUM_RD_PORTS-1:0]        rd_en_i;
    logic [NUM_RD_PORTS*ADDR_W-1:0] rd_addr_i;
    logic [NUM_RD_PORTS*XLEN-1:0]   rd_data_o;
    logic [NUM_RD_PORTS-1:0]        rd_busy_o;
    logic [NUM_WR_PORTS-1:0]        wr_en_i;
    logic [NUM_WR_PORTS*ADDR_W-1:0] wr_addr_i;
    logic [NUM_WR_PORTS*XLEN-1:0]   wr_data_i;
    logic                           rsv_en_i;
    logic [ADDR_W-1:0]              rsv_addr_i;
    logic [NUM_REGS-1:0]            busy_o;

    modport master (
        output rd_en_i, rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, rsv_en_i, rsv_addr_i,
        input  rd_data_o, rd_busy_o, busy_o
    );

    modport slave (
        input  rd_en_i, rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, rsv_en_i, rsv_addr_i,
        output rd_data_o, rd_busy_o, busy_o
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file with same-edge write-to-read bypass and a busy scoreboard.
// Latency: reads and busy updates are registered, 1 cycle; writes are visible at once through the bypass.
// Backpressure: none; every enabled read, write and reserve completes on the edge it is sampled.
module regfile_mp #(
    parameter int XLEN         = 32,
    parameter int NUM_REGS     = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int NUM_WR_PORTS = 1,
    parameter int ADDR_W       = $clog2(NUM_REGS)
) (
    input  logic        clk_i,
    input  logic        reset_i,
    regfile_mp_if.slave rf
);
    localparam logic [ADDR_W:0] NREGS = (ADDR_W+1)'(NUM_REGS);

    // x0 and addresses beyond the implemented depth are never stored or reserved
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a != '0) && ({1'b0, a} < NREGS);
    endfunction

    logic [XLEN-1:0]              regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]          busy_q, busy_d;
    logic [NUM_RD_PORTS*XLEN-1:0] rd_data_q, rd_data_d;
    logic [NUM_RD_PORTS-1:0]      rd_busy_q, rd_busy_d;

    logic [NUM_WR_PORTS-1:0] wr_vld;
    logic [ADDR_W-1:0]       wr_addr [NUM_WR_PORTS];
    logic [XLEN-1:0]         wr_dat  [NUM_WR_PORTS];
    logic [ADDR_W-1:0]       rd_addr [NUM_RD_PORTS];
    logic                    rsv_vld;

    for (genvar w = 0; w < NUM_WR_PORTS; w++) begin : g_wr
        assign wr_addr[w] = rf.wr_addr_i[w*ADDR_W +: ADDR_W];
        assign wr_dat[w]  = rf.wr_data_i[w*XLEN +: XLEN];
        assign wr_vld[w]  = rf.wr_en_i[w] && addr_ok(wr_addr[w]);
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        assign rd_addr[p] = rf.rd_addr_i[p*ADDR_W +: ADDR_W];
    end

    assign rsv_vld = rf.rsv_en_i && addr_ok(rf.rsv_addr_i);

    // Reserve is applied after the clears: it belongs to a newer producer than the writeback
    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < NUM_WR_PORTS; w++) begin
            if (wr_vld[w]) busy_d[wr_addr[w]] = 1'b0;
        end
        if (rsv_vld) busy_d[rf.rsv_addr_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Later write ports override earlier ones; a same-cycle reserve never shows on rd_busy
    always_comb begin
        rd_data_d = rd_data_q;
        rd_busy_d = rd_busy_q;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            if (rf.rd_en_i[p]) begin
                rd_data_d[p*XLEN +: XLEN] = '0;
                rd_busy_d[p]              = 1'b0;
                if (addr_ok(rd_addr[p])) begin
                    rd_data_d[p*XLEN +: XLEN] = regs_q[rd_addr[p]];
                    rd_busy_d[p]              = busy_q[rd_addr[p]];
                    for (int w = 0; w < NUM_WR_PORTS; w++) begin
                        if (wr_vld[w] && (wr_addr[w] == rd_addr[p])) begin
                            rd_data_d[p*XLEN +: XLEN] = wr_dat[w];
                            rd_busy_d[p]              = 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            busy_q    <= '0;
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            for (int w = 0; w < NUM_WR_PORTS; w++) begin
                if (wr_vld[w]) regs_q[wr_addr[w]] <= wr_dat[w];
            end
            busy_q    <= busy_d;
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign rf.rd_data_o = rd_data_q;
    assign rf.rd_busy_o = rd_busy_q;
    assign rf.busy_o    = busy_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: 24 registers, 2 read ports, 2 write ports, checked against an array model.
module tb_regfile_mp;
    localparam int XLEN = 32;
    localparam int NR   = 24;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic clk_i   = 1'b0;
    logic reset_i = 1'b1;

    regfile_mp_if #(.XLEN(XLEN), .NUM_REGS(NR), .NUM_RD_PORTS(NRD), .NUM_WR_PORTS(NWR)) rf ();

    regfile_mp #(.XLEN(XLEN), .NUM_REGS(NR), .NUM_RD_PORTS(NRD), .NUM_WR_PORTS(NWR)) u_dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .rf      (rf.slave)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errs   = 0;

    // Architectural model: register contents, scoreboard bits, and the last loaded read results
    logic [XLEN-1:0] m_regs [NR];
    bit              m_busy [NR];
    logic [XLEN-1:0] m_rdd  [NRD];
    bit              m_rdb  [NRD];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        for (int p = 0; p < NRD; p++) begin
            m_rdd[p] = '0;
            m_rdb[p] = 1'b0;
        end
    endtask

    // Reads see the array as it stands after this edge's writes, which is what the bypass promises
    task automatic model_step();
        logic [XLEN-1:0] nregs [NR];
        bit nbusy [NR];
        bit wrote [NR];
        int a;
        nregs = m_regs;
        nbusy = m_busy;
        for (int i = 0; i < NR; i++) wrote[i] = 1'b0;
        for (int w = 0; w < NWR; w++) begin
            a = int'(rf.wr_addr_i[w*AW +: AW]);
            if (rf.wr_en_i[w] && a != 0 && a < NR) begin
                nregs[a] = rf.wr_data_i[w*XLEN +: XLEN];
                nbusy[a] = 1'b0;
                wrote[a] = 1'b1;
            end
        end
        a = int'(rf.rsv_addr_i);
        if (rf.rsv_en_i && a != 0 && a < NR) nbusy[a] = 1'b1;
        for (int p = 0; p < NRD; p++) begin
            if (rf.rd_en_i[p]) begin
                a = int'(rf.rd_addr_i[p*AW +: AW]);
                if (a == 0 || a >= NR) begin
                    m_rdd[p] = '0;
                    m_rdb[p] = 1'b0;
                end else begin
                    m_rdd[p] = nregs[a];
                    m_rdb[p] = m_busy[a] && !wrote[a];
                end
            end
        end
        m_regs = nregs;
        m_busy = nbusy;
    endtask

    task automatic compare_all(input string tag);
        logic [NR-1:0] bv;
        for (int i = 0; i < NR; i++) bv[i] = m_busy[i];
        check({tag, " busy_o"}, 64'(rf.busy_o), 64'(bv));
        for (int p = 0; p < NRD; p++) begin
            check($sformatf("%s rd_data[%0d]", tag, p), 64'(rf.rd_data_o[p*XLEN +: XLEN]), 64'(m_rdd[p]));
            check($sformatf("%s rd_busy[%0d]", tag, p), 64'(rf.rd_busy_o[p]), 64'(m_rdb[p]));
        end
    endtask

    task automatic set_idle();
        rf.rd_en_i    = '0;
        rf.rd_addr_i  = '0;
        rf.wr_en_i    = '0;
        rf.wr_addr_i  = '0;
        rf.wr_data_i  = '0;
        rf.rsv_en_i   = 1'b0;
        rf.rsv_addr_i = '0;
    endtask

    task automatic set_wr(input int w, input logic [AW-1:0] addr, input logic [XLEN-1:0] dat);
        rf.wr_en_i[w]              = 1'b1;
        rf.wr_addr_i[w*AW +: AW]   = addr;
        rf.wr_data_i[w*XLEN +: XLEN] = dat;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] addr);
        rf.rd_en_i[p]            = 1'b1;
        rf.rd_addr_i[p*AW +: AW] = addr;
    endtask

    task automatic set_rsv(input logic [AW-1:0] addr);
        rf.rsv_en_i   = 1'b1;
        rf.rsv_addr_i = addr;
    endtask

    // Inputs are set at the falling edge; outputs are sampled 1 time unit after the rising edge
    task automatic step(input string tag);
        model_step();
        @(posedge clk_i);
        #1;
        compare_all(tag);
        @(negedge clk_i);
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < NR; a += 2) begin
            set_idle();
            set_rd(0, AW'(a));
            set_rd(1, AW'(a + 1));
            step(tag);
        end
    endtask

    initial begin
        set_idle();
        model_reset();
        #1;
        check("reset rd_data_o", 64'(rf.rd_data_o), 64'h0);
        check("reset rd_busy_o", 64'(rf.rd_busy_o), 64'h0);
        check("reset busy_o", 64'(rf.busy_o), 64'h0);
        @(negedge clk_i);
        reset_i = 1'b0;

        // Write x7 from port 0 only, then read x7 and x0
        set_idle(); set_wr(0, 5'd7, 32'hDEADBEEF); step("wr_x7");
        set_idle(); set_rd(0, 5'd7); set_rd(1, 5'd0); step("rd_x7");
        check("x7 rd_data", 64'(rf.rd_data_o), 64'h00000000_DEADBEEF);

        set_idle(); set_wr(0, 5'd0, 32'h1234); set_rd(1, 5'd0); step("wr_x0");
        check("x0 bypass", 64'(rf.rd_data_o[63:32]), 64'h0);
        set_idle(); set_rd(1, 5'd0); step("rd_x0");
        check("x0 read", 64'(rf.rd_data_o[63:32]), 64'h0);

        // Bypass on a reserved register: new data, not busy
        set_idle(); set_rsv(5'd3); step("rsv_x3");
        set_idle(); set_wr(0, 5'd3, 32'hA5A5A5A5); set_rd(0, 5'd3); step("byp_x3");
        check("x3 bypass data", 64'(rf.rd_data_o[31:0]), 64'hA5A5A5A5);
        check("x3 bypass busy", 64'(rf.rd_busy_o[0]), 64'h0);

        // Dual-write conflict: higher port index wins, bypassed and stored
        set_idle(); set_wr(0, 5'd9, 32'h11111111); set_wr(1, 5'd9, 32'h22222222); set_rd(0, 5'd9);
        step("dual_x9");
        check("x9 bypass", 64'(rf.rd_data_o[31:0]), 64'h22222222);
        set_idle(); set_rd(1, 5'd9); step("rd_x9");
        check("x9 stored", 64'(rf.rd_data_o[63:32]), 64'h22222222);

        // Scoreboard sequence on x12
        set_idle(); set_rsv(5'd12); step("rsv_x12");
        check("x12 busy after rsv", 64'(rf.busy_o[12]), 64'h1);
        set_idle(); set_rd(0, 5'd12); step("rd_x12");
        check("x12 rd_busy", 64'(rf.rd_busy_o[0]), 64'h1);
        set_idle(); set_wr(0, 5'd12, 32'hCAFEF00D); set_rsv(5'd12); set_rd(1, 5'd12); step("wr_rsv_x12");
        check("x12 busy after wr+rsv", 64'(rf.busy_o[12]), 64'h1);
        check("x12 own-dest rd_busy", 64'(rf.rd_busy_o[1]), 64'h0);
        set_idle(); set_wr(1, 5'd12, 32'h0BADC0DE); step("wr_x12");
        check("x12 busy after wr", 64'(rf.busy_o[12]), 64'h0);

        // Hold: load x7/x9 into the outputs, then keep reads disabled across array writes
        set_idle(); set_rd(0, 5'd7); set_rd(1, 5'd9); step("load_hold");
        for (int c = 0; c < 3; c++) begin
            set_idle(); set_wr(0, 5'd7, $urandom); set_wr(1, 5'd9, $urandom); set_rsv(5'd7);
            step("hold");
            check("hold rd_data", 64'(rf.rd_data_o), 64'h22222222_DEADBEEF);
        end

        // Out-of-range address 30 on a 24-entry file
        set_idle(); set_rsv(5'd30); step("rsv_30");
        set_idle(); set_rd(0, 5'd30); step("rd_30");
        check("addr30 data", 64'(rf.rd_data_o[31:0]), 64'h0);
        check("addr30 busy", 64'(rf.rd_busy_o[0]), 64'h0);
        set_idle(); set_wr(0, 5'd30, 32'hFFFFFFFF); set_wr(1, 5'd31, 32'hEEEEEEEE); set_rd(1, 5'd30); step("wr_30");
        check("addr30 bypass", 64'(rf.rd_data_o[63:32]), 64'h0);
        sweep("sweep_after_30");

        // Randomised traffic, biased towards a few registers to provoke conflicts and bypasses
        for (int c = 0; c < 400; c++) begin
            set_idle();
            for (int w = 0; w < NWR; w++) begin
                if ($urandom_range(0, 3) != 0)
                    set_wr(w, $urandom_range(0, 1) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 3)), $urandom);
            end
            if ($urandom_range(0, 2) == 0)
                set_rsv($urandom_range(0, 1) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 3)));
            for (int p = 0; p < NRD; p++) begin
                if ($urandom_range(0, 3) != 0) begin
                    if ($urandom_range(0, 2) == 0) set_rd(p, rf.wr_addr_i[AW-1:0]);
                    else set_rd(p, AW'($urandom_range(0, 31)));
                end
            end
            step("rand");
        end
        sweep("sweep_rand");

        // Asynchronous reset mid-cycle, with a write and reserve in flight
        set_idle(); set_rsv(5'd5); set_wr(0, 5'd6, 32'h13579BDF); set_rd(0, 5'd6); step("pre_rst");
        set_idle(); set_wr(0, 5'd5, 32'h5A5A5A5A); set_rsv(5'd8); set_rd(0, 5'd5);
        #2;
        reset_i = 1'b1;
        #1;
        check("async rst rd_data_o", 64'(rf.rd_data_o), 64'h0);
        check("async rst rd_busy_o", 64'(rf.rd_busy_o), 64'h0);
        check("async rst busy_o", 64'(rf.busy_o), 64'h0);
        model_reset();
        @(negedge clk_i);
        reset_i = 1'b0;
        set_idle(); set_rd(0, 5'd5); step("post_rst");
        check("x5 after rst data", 64'(rf.rd_data_o[31:0]), 64'h0);
        check("x5 after rst busy", 64'(rf.rd_busy_o[0]), 64'h0);
        sweep("sweep_post_rst");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with a built-in scoreboard. It extends the single-write, dual-read system register bank in the following ways:
- configurable width, depth, read-port count and write-port count;
- same-cycle write-to-read bypass;
- a per-register busy (pending-write) bit that issue logic sets and writeback clears.

It sits between decode/issue and the execute/writeback stages of the core.

## Interface
Parameters:
- XLEN, 32, data width of each register
- NUM_REGS, 32, number of architectural registers (2..64); register 0 is hardwired zero
- NUM_RD_PORTS, 2, read ports (1..4)
- NUM_WR_PORTS, 1, write ports (1..2)
- ADDR_W, $clog2(NUM_REGS), derived; not to be overridden

Ports:
- clk_i  in  1  system clock; all state updates on its rising edge
- reset_i  in  1  one clock; reset is asynchronous and active-high
- rd_en_i  in  NUM_RD_PORTS  per-port read enable
- rd_addr_i  in  NUM_RD_PORTS*ADDR_W  read addresses; port p uses slice [p*ADDR_W +: ADDR_W]
- rd_data_o  out  NUM_RD_PORTS*XLEN  registered read data
- rd_busy_o  out  NUM_RD_PORTS  registered busy flag of the addressed register
- wr_en_i  in  NUM_WR_PORTS  per-port write enable (writeback)
- wr_addr_i  in  NUM_WR_PORTS*ADDR_W  write addresses
- wr_data_i  in  NUM_WR_PORTS*XLEN  write data
- rsv_en_i  in  1  reserve request from issue (sets busy)
- rsv_addr_i  in  ADDR_W  register to reserve
- busy_o  out  NUM_REGS  current scoreboard vector; bit 0 is always 0

## Operation
- Reset (asynchronous assert, synchronous release to clk_i) clears:
  - all registers to 0;
  - rd_data_o, rd_busy_o and busy_o to 0.
- Write: on a rising edge with wr_en_i[w]=1, address A≠0 and A<NUM_REGS, register A takes wr_data_i[w].
  - Writes to address 0 or to an address ≥NUM_REGS are ignored.
  - If two write ports target the same address in the same cycle, the higher port index wins.
- Busy clear: a valid write to A clears busy[A] on the same edge.
- Busy set: rsv_en_i=1 with rsv_addr_i=A, where A≠0 and A<NUM_REGS, sets busy[A].
  - Reserve and write to the same A in one cycle leaves busy[A]=1, because the reserve belongs to a newer producer.
  - Reserve of an already-busy register keeps it at 1. There is no counting; the issue stage must not allow two outstanding writers to one register.
- Read, per port p: when rd_en_i[p]=1, the outputs are loaded on the edge as follows.
  - rd_data_o[p] loads one of:
    - 0 if the address is 0 or ≥NUM_REGS;
    - otherwise, if any valid write targets the same address this cycle, that write's data (highest write index on a tie) — this is the bypass;
    - otherwise the stored register value.
  - rd_busy_o[p] loads busy[addr] AND NOT (any valid write to addr this cycle).
    - A same-cycle reserve is deliberately excluded, so an instruction reading its own destination sees "not busy".
    - Address 0 and out-of-range addresses read as not busy.
- When rd_en_i[p]=0, rd_data_o[p] and rd_busy_o[p] hold their previous values.
- Read ports are fully independent; any number may read the same address.
- busy_o is the registered scoreboard state, with no combinational path from inputs.
- Reset mid-operation: all state clears immediately, regardless of clock. Any in-flight write or reserve in that cycle is lost.

## Timing
- Read latency is 1 cycle: address and enable sampled at edge N, data valid after edge N.
- Write latency is 1 cycle for the array, and 0 cycles effective through the bypass: a read sampled on the same edge returns the new data.
- busy_o updates on the edge of the reserve or clear; it is visible the cycle after.
- There are no combinational paths from any input to any output.
- The block has no stalls or backpressure; every enabled request completes in one cycle.

## Test plan
- **Reset:** assert reset_i asynchronously mid-cycle after filling the registers.
  - Required: outputs go to 0 immediately.
  - Required: reads of x5 after reset return 0 with rd_busy_o=0.
- **Write then read and x0:** with NUM_WR_PORTS=1, write x7=0xDEADBEEF, then read x7 on port 0 and x0 on port 1 the next cycle.
  - Required: rd_data_o = {0x00000000, 0xDEADBEEF}.
  - Required: a write of 0x1234 to x0 is ignored.
- **Bypass:** write x3=0xA5A5A5A5 and read x3 on the same edge.
  - Required: rd_data_o[0]=0xA5A5A5A5 and rd_busy_o[0]=0.
- **Dual-write conflict:** with NUM_WR_PORTS=2, write x9 from port 0 with 0x11111111 and from port 1 with 0x22222222 in the same cycle.
  - Required: x9 reads 0x22222222, including on a bypassed same-cycle read.
- **Scoreboard:** reserve x12, then read x12 the next cycle, then write x12 while also reserving x12.
  - Required: busy_o[12]=1 after the reserve.
  - Required: rd_busy_o=1 on the next-cycle read.
  - Required: busy_o[12] stays 1 after the simultaneous write and reserve.
  - Then a plain write to x12 → busy_o[12]=0.
- **Hold and non-power-of-2 depth:** with NUM_REGS=24, deassert rd_en_i.
  - Required: outputs are unchanged across 3 cycles of array writes.
  - Required: a read of address 30 returns 0 with busy 0.
  - Required: a write to address 30 changes no register.
